// File: rtl/rf_onehot_store_if.sv
// Bus between the write-address decoder / read requester and the one-hot
// register file: write select and data, read request and addresses, error
// clear, and the registered read data and status coming back.
interface rf_onehot_store_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       we_sel;
  logic [DATA_W-1:0] wdata;
  logic              rd_req;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic              err_clr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [4:0]        wsel_idx;
  logic              wsel_err;
  logic              err_sticky;

  modport master (
    output we_sel, wdata, rd_req, ra1, ra2, err_clr,
    input  rd_valid, rd1, rd2, wsel_idx, wsel_err, err_sticky
  );

  modport slave (
    input  we_sel, wdata, rd_req, ra1, ra2, err_clr,
    output rd_valid, rd1, rd2, wsel_idx, wsel_err, err_sticky
  );
endinterface

// File: rtl/rf_onehot_store.sv
// 32-entry register file written through a one-hot select. The select is
// encoded back to a binary index and rejected when more than one bit is set.
// Two registered read ports with write-to-read bypass; entry 0 can be
// hardwired to zero.
module rf_onehot_store #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  rf_onehot_store_if.slave bus
);
  localparam int NREG = 32;

  logic [DATA_W-1:0] r_mem [NREG];

  logic [4:0]        w_idx;
  logic              w_any;
  logic              w_multi;
  logic              w_one;
  logic              w_wr;
  logic [DATA_W-1:0] w_rd1_p0;
  logic [DATA_W-1:0] w_rd2_p0;

  logic              r_vld_p1;
  logic [DATA_W-1:0] r_rd1_p1;
  logic [DATA_W-1:0] r_rd2_p1;
  logic [4:0]        r_wsel_idx;
  logic              r_wsel_err;
  logic              r_err_sticky;

  // Read value of one port: zero register, then same-cycle write bypass,
  // then stored contents.
  function automatic logic [DATA_W-1:0] rd_sel(input logic [4:0] ra);
    logic [DATA_W-1:0] v;
    if (ZERO_REG && (ra == 5'd0))
      v = '0;
    else if (w_wr && (w_idx == ra))
      v = bus.wdata;
    else
      v = r_mem[ra];
    return v;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign w_any   = |bus.we_sel;
  assign w_multi = |(bus.we_sel & (bus.we_sel - 32'd1));
  assign w_one   = w_any & ~w_multi;
  assign w_wr    = w_one & ~(ZERO_REG && (w_idx == 5'd0));

  // One-hot to binary encoder; only meaningful when exactly one bit is set.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.we_sel[i]) w_idx = i[4:0];
    end
  end

  // Read-port selection for this cycle's request.
  always_comb begin
    w_rd1_p0 = rd_sel(bus.ra1);
    w_rd2_p0 = rd_sel(bus.ra2);
  end

  // Storage array: cleared by reset, one entry updated per valid write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[w_idx] <= bus.wdata;
    end
  end

  // ---- stage p0 -> p1: registered read ports ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_rd1_p1 <= '0;
      r_rd2_p1 <= '0;
    end else begin
      r_vld_p1 <= bus.rd_req;
      if (bus.rd_req) begin
        r_rd1_p1 <= w_rd1_p0;
        r_rd2_p1 <= w_rd2_p0;
      end
    end
  end

  // Write-select status: last accepted index, error pulse and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wsel_idx   <= '0;
      r_wsel_err   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_one) r_wsel_idx <= w_idx;
      r_wsel_err <= w_multi;
      if (w_multi)
        r_err_sticky <= 1'b1;
      else if (bus.err_clr)
        r_err_sticky <= 1'b0;
    end
  end

  assign bus.rd_valid   = r_vld_p1;
  assign bus.rd1        = r_rd1_p1;
  assign bus.rd2        = r_rd2_p1;
  assign bus.wsel_idx   = r_wsel_idx;
  assign bus.wsel_err   = r_wsel_err;
  assign bus.err_sticky = r_err_sticky;
endmodule

// File: tb/tb_rf_onehot_store.sv
// Randomised bench for rf_onehot_store with a behavioural reference model
// and a few hand-computed directed checks.
module tb_rf_onehot_store;
  localparam int DATA_W = 32;

  logic clk;
  logic rst_n;

  rf_onehot_store_if #(.DATA_W(DATA_W)) bus ();

  rf_onehot_store #(.DATA_W(DATA_W), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [DATA_W-1:0] m_mem [32];
  logic [DATA_W-1:0] m_rd1, m_rd2;
  logic              m_vld;
  logic [4:0]        m_idx;
  logic              m_err;
  logic              m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int ra, input bit wr, input int widx,
                                                   input logic [DATA_W-1:0] wd);
    if (ra == 0) return '0;
    if (wr && widx == ra) return wd;
    return m_mem[ra];
  endfunction

  // Advance one clock: update the model from the current inputs, clock the
  // DUT, then compare every output just after the edge.
  task automatic step();
    int pc;
    int widx;
    bit wr;
    pc   = $countones(bus.we_sel);
    widx = 0;
    for (int i = 0; i < 32; i++) if (bus.we_sel[i]) widx = i;
    wr = (pc == 1) && (widx != 0);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_rd1 = '0; m_rd2 = '0; m_vld = 1'b0;
      m_idx = '0; m_err = 1'b0; m_sticky = 1'b0;
    end else begin
      m_vld = bus.rd_req;
      if (bus.rd_req) begin
        m_rd1 = model_read(int'(bus.ra1), wr, widx, bus.wdata);
        m_rd2 = model_read(int'(bus.ra2), wr, widx, bus.wdata);
      end
      if (pc == 1) m_idx = widx[4:0];
      if (wr) m_mem[widx] = bus.wdata;
      m_err = (pc >= 2);
      if (pc >= 2) m_sticky = 1'b1;
      else if (bus.err_clr) m_sticky = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rd_valid",   {31'b0, bus.rd_valid},   {31'b0, m_vld});
    check("rd1",        bus.rd1,                 m_rd1);
    check("rd2",        bus.rd2,                 m_rd2);
    check("wsel_idx",   {27'b0, bus.wsel_idx},   {27'b0, m_idx});
    check("wsel_err",   {31'b0, bus.wsel_err},   {31'b0, m_err});
    check("err_sticky", {31'b0, bus.err_sticky}, {31'b0, m_sticky});
  endtask

  task automatic idle();
    bus.we_sel  = '0;
    bus.wdata   = '0;
    bus.rd_req  = 1'b0;
    bus.ra1     = '0;
    bus.ra2     = '0;
    bus.err_clr = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    idle();
    bus.we_sel = 32'd1 << idx;
    bus.wdata  = d;
    step();
  endtask

  initial begin
    int a, b, r;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 'x;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Read after reset
    idle(); bus.rd_req = 1'b1; bus.ra1 = 5'd5; bus.ra2 = 5'd31;
    step();
    check("lit_rst_vld", {31'b0, bus.rd_valid}, 32'd1);
    check("lit_rst_rd1", bus.rd1, 32'd0);
    check("lit_rst_rd2", bus.rd2, 32'd0);
    check("lit_rst_sticky", {31'b0, bus.err_sticky}, 32'd0);

    // Write then read entry 5
    idle(); bus.we_sel = 32'h0000_0020; bus.wdata = 32'hDEAD_BEEF;
    step();
    idle(); bus.rd_req = 1'b1; bus.ra1 = 5'd5;
    step();
    check("lit_wr5_rd1", bus.rd1, 32'hDEAD_BEEF);
    check("lit_wr5_idx", {27'b0, bus.wsel_idx}, 32'd5);

    // Same-cycle bypass on both ports
    idle(); bus.we_sel = 32'h8000_0000; bus.wdata = 32'h1234_5678;
    bus.rd_req = 1'b1; bus.ra1 = 5'd31; bus.ra2 = 5'd31;
    step();
    check("lit_byp_rd1", bus.rd1, 32'h1234_5678);
    check("lit_byp_rd2", bus.rd2, 32'h1234_5678);

    // Multi-hot write is rejected and reads see prior contents
    wr(8, 32'h0000_0011);
    wr(9, 32'h0000_0022);
    idle(); bus.we_sel = 32'h0000_0300; bus.wdata = 32'hFFFF_FFFF;
    bus.rd_req = 1'b1; bus.ra1 = 5'd8; bus.ra2 = 5'd9;
    step();
    check("lit_mh_err", {31'b0, bus.wsel_err}, 32'd1);
    check("lit_mh_sticky", {31'b0, bus.err_sticky}, 32'd1);
    check("lit_mh_rd1", bus.rd1, 32'h0000_0011);
    check("lit_mh_rd2", bus.rd2, 32'h0000_0022);
    check("lit_mh_idx", {27'b0, bus.wsel_idx}, 32'd9);
    idle(); bus.err_clr = 1'b1;
    step();
    check("lit_clr_err", {31'b0, bus.wsel_err}, 32'd0);
    check("lit_clr_sticky", {31'b0, bus.err_sticky}, 32'd0);

    // Error and clear in the same cycle: set wins
    idle(); bus.we_sel = 32'h0000_0003; bus.err_clr = 1'b1;
    step();
    check("lit_setwins", {31'b0, bus.err_sticky}, 32'd1);
    idle(); bus.err_clr = 1'b1;
    step();

    // Zero register: write discarded, same-cycle and later reads give 0
    idle(); bus.we_sel = 32'h0000_0001; bus.wdata = 32'hAAAA_AAAA;
    bus.rd_req = 1'b1; bus.ra1 = 5'd0;
    step();
    check("lit_z_rd1a", bus.rd1, 32'd0);
    check("lit_z_err", {31'b0, bus.wsel_err}, 32'd0);
    check("lit_z_idx", {27'b0, bus.wsel_idx}, 32'd0);
    idle(); bus.rd_req = 1'b1; bus.ra1 = 5'd0;
    step();
    check("lit_z_rd1b", bus.rd1, 32'd0);

    // Reset mid-stream drops the read and write presented with it
    wr(3, 32'h0000_0055);
    idle(); rst_n = 1'b0; bus.rd_req = 1'b1; bus.ra1 = 5'd3;
    bus.we_sel = 32'h0000_0010; bus.wdata = 32'h0000_0077;
    step();
    check("lit_rst_mid_vld", {31'b0, bus.rd_valid}, 32'd0);
    rst_n = 1'b1;
    idle(); bus.rd_req = 1'b1; bus.ra1 = 5'd3; bus.ra2 = 5'd4;
    step();
    check("lit_rst_mid_rd1", bus.rd1, 32'd0);
    check("lit_rst_mid_rd2", bus.rd2, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
      r = $urandom_range(0, 99);
      a = $urandom_range(0, 31);
      if (r < 25) begin
        bus.we_sel = '0;
      end else if (r < 80) begin
        bus.we_sel = 32'd1 << a;
      end else begin
        b = (a + 1 + $urandom_range(0, 30)) % 32;
        bus.we_sel = (32'd1 << a) | (32'd1 << b) | ($urandom_range(0, 3) == 0 ? $urandom : 32'd0);
      end
      bus.wdata   = $urandom;
      bus.rd_req  = ($urandom_range(0, 9) < 7);
      bus.ra1     = ($urandom_range(0, 9) < 3) ? a[4:0] : 5'($urandom_range(0, 31));
      bus.ra2     = ($urandom_range(0, 9) < 3) ? a[4:0] : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) bus.ra2 = bus.ra1;
      bus.err_clr = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_onehot_store.md
Name: rf_onehot_store

Overview:
- 32-entry register file that sits on the write side of the one-hot write-select produced by the 5-to-32 write-address decoder.
- Encodes the one-hot select back to a binary index and checks that it is valid (exactly one bit set).
- Stores the write data and serves two registered read ports with write-to-read bypass.
- Register 0 reads as zero when ZERO_REG=1.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and writes to it are discarded.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- we_sel  input  32  one-hot write select from the write-address decoder; all-zero means no write.
- wdata  input  DATA_W  write data.
- rd_req  input  1  read request; samples ra1 and ra2 this cycle.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- err_clr  input  1  clears the sticky error flag.
- rd_valid  output  1  read data valid, one cycle after rd_req.
- rd1  output  DATA_W  read data, port 1.
- rd2  output  DATA_W  read data, port 2.
- wsel_idx  output  5  registered binary index of the last accepted write.
- wsel_err  output  1  one-cycle pulse when we_sel has more than one bit set.
- err_sticky  output  1  latched OR of all wsel_err pulses.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: rst_n=0 at a rising edge clears all 32 entries, rd1, rd2, rd_valid, wsel_idx, wsel_err and err_sticky to 0.
  - Reset has priority over every other input.
  - A read or write presented in the reset cycle is dropped.
- Encode: popcount(we_sel) is 0, 1, or ≥2.
  - 0: no write, no error.
  - 1: idx = position of the set bit; valid write.
  - ≥2: the write is discarded, no entry changes, and wsel_err=1 on the next cycle only.
- Write: a valid write updates mem[idx] <= wdata at the rising edge, and wsel_idx <= idx on the same edge.
  - If idx=0 and ZERO_REG=1, the write is discarded and wsel_idx still updates to 0 with no error.
  - Between valid writes, wsel_idx holds its last value.
- Read: rd_req=1 in cycle N gives rd_valid=1 in cycle N+1.
  - rd1 = mem[ra1] and rd2 = mem[ra2], values as of before the cycle-N edge.
  - With rd_req=0, rd_valid=0 in the next cycle and rd1/rd2 hold their previous values.
- Bypass: if a valid write in cycle N targets ra1 (or ra2), the matching port returns wdata of cycle N.
  - Exception: address 0 with ZERO_REG=1 always returns 0.
  - Both ports may bypass in the same cycle.
- Simultaneous events: for the same ra1 and ra2, both ports return identical data.
  - A read request and a rejected (multi-hot) write in the same cycle: the read returns old contents, no bypass.
- Error flag: err_sticky sets one cycle after a multi-hot we_sel (together with wsel_err).
  - err_clr=1 clears err_sticky at the edge.
  - When err_clr and a new error occur in the same cycle, set wins.
- Latency: write to read-visible takes 0 cycles (through bypass). Read latency is 1 cycle, fully pipelined, one request per cycle.
- Each write takes effect on exactly one entry; no X propagation from unwritten entries, since reset clears them.

Test Plan:
- Reset, then rd_req with ra1=5, ra2=31 → next cycle rd_valid=1, rd1=0, rd2=0, err_sticky=0.
- we_sel=32'h0000_0020, wdata=32'hDEAD_BEEF in cycle N; rd_req with ra1=5 in cycle N+1 → rd1=32'hDEAD_BEEF in N+2, wsel_idx=5.
- Same-cycle bypass: we_sel=32'h8000_0000, wdata=32'h1234_5678, rd_req with ra1=31, ra2=31 in the same cycle → next cycle rd1=rd2=32'h1234_5678.
- Multi-hot: we_sel=32'h0000_0300, wdata=32'hFFFF_FFFF → wsel_err pulses for 1 cycle, err_sticky=1, and reads of entries 8 and 9 return the prior values; err_clr=1 → err_sticky=0 next cycle.
- ZERO_REG: we_sel=32'h0000_0001, wdata=32'hAAAA_AAAA, then a read with ra1=0 (also in the same cycle) → rd1=0 both times, no error.
- Reset mid-stream: write 32'h55 to entry 3, then assert rst_n=0 together with rd_req and a write to entry 4 → after reset, entries 3 and 4 read 0 and rd_valid=0 in the cycle after the reset edge.
